// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and sign-correction helper for the
// iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Widest operand the helper supports; callers zero-extend into wide_t and
    // truncate the result, which is exact because negation is modular.
    localparam int unsigned MAX_W = 64;

    typedef logic [2*MAX_W-1:0] wide_t;

    function automatic wide_t sign_fix(input logic neg, input wide_t v);
        return neg ? (~v + wide_t'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a radix-2 shift-add multiply step or a
// restoring divide step, selected by mode_i.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        addend = acc_i[0] ? opnd_i : '0;
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};

        // Divide: acc = {partial remainder, dividend/quotient}; the remainder
        // fits WIDTH bits after each step, only the shifted value needs WIDTH+1.
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd_i;
        ge      = (shifted >= {1'b0, opnd_i});

        if (mode_i == MODE_DIV) begin
            acc_o = {(ge ? diff : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO writes and a start/busy/done handshake for the hazard unit.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic                 in_signed;
    logic                 in_div;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 q_signed;
    logic                 q_div;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (q_div ? MODE_DIV : MODE_MUL),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        in_div    = (op == OP_DIV)  || (op == OP_DIVU);
        mag1      = WIDTH'(sign_fix(in_signed & in1[WIDTH-1], wide_t'(in1)));
        mag2      = WIDTH'(sign_fix(in_signed & in2[WIDTH-1], wide_t'(in2)));

        q_signed  = (op_q == OP_MULT) || (op_q == OP_DIV);
        q_div     = (op_q == OP_DIV)  || (op_q == OP_DIVU);
        prod      = (2*WIDTH)'(sign_fix(q_signed & (sa_q ^ sb_q), wide_t'(acc_q)));
        quo       = WIDTH'(sign_fix(q_signed & (sa_q ^ sb_q), wide_t'(acc_q[WIDTH-1:0])));
        rem       = WIDTH'(sign_fix(q_signed & sa_q, wide_t'(acc_q[2*WIDTH-1:WIDTH])));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start) begin
                    op_d  = op;
                    sa_d  = in1[WIDTH-1];
                    sb_d  = in2[WIDTH-1];
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (in_div && (in2 == '0)) begin
                        // Raw dividend parked in acc low half so FIX can return it as HI.
                        acc_d   = {{WIDTH{1'b0}}, in1};
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else if (in_div) begin
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                        opnd_d  = mag2;
                        state_d = CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                        opnd_d  = mag1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else if (q_div) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 with a cycle-level reference model.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int last_bc  = 0;

    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    logic [1:0]  vo [6] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] va [6] = '{32'd7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vb [6] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'h10, 32'd7};

    always #5 clk = ~clk;

    alu_muldiv #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // {HI, LO} of an operation computed with native integer arithmetic.
    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb, q, r;
        longint      la, lb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                la = sa;
                lb = sb;
                p  = la * lb;
            end
            2'b01: p = {32'h0, a} * {32'h0, b};
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else if (o == 2'b11) p = {a % b, a / b};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else begin
            m_done <= 1'b0;
            if (wr_hi) m_hi <= wr_data;
            if (wr_lo) m_lo <= wr_data;
            if (start) begin
                {p_hi, p_lo} <= model_res(op, in1, in2);
                m_dz  <= op[1] && (in2 == 32'h0);
                m_rem <= (op[1] && (in2 == 32'h0)) ? 1 : 33;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 60) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int lat, bc;
        @(negedge clk);
        issue(o, a, b);
        wait_done(lat, bc);
        last_bc = bc;
        chk({name, "_lat"}, lat, elat);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int          lat, bc, pulses;
        logic [63:0] r;

        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        chk("multu_busy_cycles", last_bc, 32'd33);
        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        run("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

        // MTLO in the accept cycle lands now and is later overwritten by the quotient.
        @(negedge clk);
        wr_lo   = 1'b1;
        wr_data = 32'h5A5A5A5A;
        issue(2'b11, 32'd7, 32'd2);
        wr_lo = 1'b0;
        chk("mtlo_with_start", lo, 32'h5A5A5A5A);
        wait_done(lat, bc);
        chk("divu_lat", lat, 32'd33);
        chk("divu_hi", hi, 32'd1);
        chk("divu_lo", lo, 32'd3);

        for (int i = 0; i < 6; i++) begin
            r = model_res(vo[i], va[i], vb[i]);
            run("vec", vo[i], va[i], vb[i], r[63:32], r[31:0], 33);
        end

        @(negedge clk);
        issue(2'b11, 32'h12345678, 32'h0);
        wait_done(lat, bc);
        chk("dz_lat", lat, 32'd1);
        chk("dz_hi", hi, 32'h12345678);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_flag", {31'b0, div_by_zero}, 32'd1);
        // Back-to-back start issued in the done cycle.
        issue(2'b11, 32'd100, 32'd7);
        chk("b2b_accept", {31'b0, busy}, 32'd1);
        chk("dz_cleared", {31'b0, div_by_zero}, 32'd0);
        wait_done(lat, bc);
        chk("b2b_lat", lat, 32'd33);
        chk("b2b_hi", hi, 32'd2);
        chk("b2b_lo", lo, 32'd14);

        @(negedge clk);
        issue(2'b00, 32'd5, 32'hFFFFFFFC);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        op      = 2'b11;
        in1     = 32'd1;
        in2     = 32'd0;
        wr_hi   = 1'b1;
        wr_data = 32'hAAAA5555;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        chk("busy_start_ignored", {31'b0, div_by_zero}, 32'd0);
        chk("busy_mthi_dropped", hi, 32'd2);
        wait_done(lat, bc);
        chk("ignored_lat", lat, 32'd29);
        chk("ignored_hi", hi, 32'hFFFFFFFF);
        chk("ignored_lo", lo, 32'hFFFFFFEC);
        wr_hi   = 1'b1;
        wr_data = 32'hAAAA5555;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi_hi", hi, 32'hAAAA5555);
        chk("mthi_lo", lo, 32'hFFFFFFEC);

        @(negedge clk);
        issue(2'b01, 32'hDEADBEEF, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 32'd0);

        run("post_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 33);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
